// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the arbiter grant encoding.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_WORDS  = 76800;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_CAM  = 2'd2,
        GNT_PROC = 2'd3
    } grant_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering camera {addr, data} writes ahead of the BRAM port.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = FB_ADDR_W + FB_DATA_W,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
            else if (do_pop && !do_push) level_q <= level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display > high-water camera > processing > camera drain.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HIGH_WATER = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cam_we,
    input  logic [FB_ADDR_W-1:0] cam_addr,
    input  logic [FB_DATA_W-1:0] cam_wdata,
    input  logic                 disp_re,
    input  logic [FB_ADDR_W-1:0] disp_addr,
    output logic [FB_DATA_W-1:0] disp_rdata,
    output logic                 disp_rvalid,
    input  logic                 proc_req,
    input  logic [FB_ADDR_W-1:0] proc_addr,
    output logic                 proc_ack,
    output logic [FB_DATA_W-1:0] proc_rdata,
    output logic                 proc_rvalid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [FB_DATA_W-1:0] mem_wdata,
    input  logic [FB_DATA_W-1:0] mem_rdata,
    input  logic                 clr_overflow,
    output logic                 cam_overflow,
    output logic [3:0]           fifo_level
);

    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FIFO_W = FB_ADDR_W + FB_DATA_W;

    grant_t              grant, last_grant_q;
    logic [FIFO_W-1:0]   fifo_head;
    logic [LVL_W-1:0]    level;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
    logic                overflow_q;

    assign fifo_push = cam_we && !reset;
    assign fifo_pop  = (grant == GNT_CAM);
    assign drop      = fifo_push && fifo_full && !fifo_pop;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W),
        .LVL_W (LVL_W)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({cam_addr, cam_wdata}),
        .head  (fifo_head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        grant = GNT_NONE;
        if (reset)                            grant = GNT_NONE;
        else if (disp_re)                     grant = GNT_DISP;
        else if (level >= LVL_W'(HIGH_WATER)) grant = GNT_CAM;
        else if (proc_req)                    grant = GNT_PROC;
        else if (!fifo_empty)                 grant = GNT_CAM;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        proc_ack  = 1'b0;
        unique case (grant)
            GNT_DISP: begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end
            GNT_CAM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_head[FIFO_W-1:FB_DATA_W];
                mem_wdata = fifo_head[FB_DATA_W-1:0];
            end
            GNT_PROC: begin
                mem_en   = 1'b1;
                mem_addr = proc_addr;
                proc_ack = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_NONE;
            overflow_q   <= 1'b0;
        end else begin
            last_grant_q <= grant;
            // A drop in the clearing cycle must stay visible.
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    assign disp_rvalid  = (last_grant_q == GNT_DISP);
    assign proc_rvalid  = (last_grant_q == GNT_PROC);
    assign disp_rdata   = disp_rvalid ? mem_rdata : '0;
    assign proc_rdata   = proc_rvalid ? mem_rdata : '0;
    assign cam_overflow = overflow_q;
    assign fifo_level   = 4'(level);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_fb_port_arbiter;

    logic        clk, reset;
    logic        cam_we, disp_re, proc_req, clr_overflow;
    logic [16:0] cam_addr, disp_addr, proc_addr, mem_addr;
    logic [15:0] cam_wdata, disp_rdata, proc_rdata, mem_wdata, mem_rdata;
    logic        disp_rvalid, proc_ack, proc_rvalid, mem_en, mem_we, cam_overflow;
    logic [3:0]  fifo_level;

    logic [15:0] bram [0:76799];
    logic [16:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          checks = 0;
    int          errors = 0;

    fb_port_arbiter #(
        .FIFO_DEPTH (8),
        .HIGH_WATER (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cam_we       (cam_we),
        .cam_addr     (cam_addr),
        .cam_wdata    (cam_wdata),
        .disp_re      (disp_re),
        .disp_addr    (disp_addr),
        .disp_rdata   (disp_rdata),
        .disp_rvalid  (disp_rvalid),
        .proc_req     (proc_req),
        .proc_addr    (proc_addr),
        .proc_ack     (proc_ack),
        .proc_rdata   (proc_rdata),
        .proc_rvalid  (proc_rvalid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .clr_overflow (clr_overflow),
        .cam_overflow (cam_overflow),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    // BRAM model with registered read data; every write is logged in order.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram[mem_addr] <= mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end else if (mem_en) begin
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input int base_a, input int base_d,
                                input int n);
        check({tag, "_count"}, wr_addr_q.size(), n);
        for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            check({tag, "_addr"}, {15'd0, wr_addr_q[k]}, base_a + k);
            check({tag, "_data"}, {16'd0, wr_data_q[k]}, base_d + k);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        for (int a = 0; a < 76800; a++) bram[a] = pat(a);
        mem_rdata = '0;
        reset = 1'b1; cam_we = 0; disp_re = 0; proc_req = 0; clr_overflow = 0;
        cam_addr = '0; cam_wdata = '0; disp_addr = '0; proc_addr = '0;
        cyc();
        cyc();
        check("rst_disp_rvalid", disp_rvalid, 0);
        check("rst_proc_rvalid", proc_rvalid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", cam_overflow, 0);
        reset = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();

        // Camera only: each write hits memory the cycle after its push.
        for (int i = 0; i < 4; i++) begin
            cam_we = 1; cam_addr = 17'(i); cam_wdata = 16'hA000 + 16'(i);
            #1;
            if (i == 0) check("cam_idle_first", mem_en, 0);
            else begin
                check("cam_wr_addr", mem_addr, i - 1);
                check("cam_wr_we", mem_we, 1);
                check("cam_level", fifo_level, 1);
            end
            cyc();
        end
        cam_we = 0;
        #1;
        check("cam_last_addr", mem_addr, 3);
        cyc();
        check("cam_level_empty", fifo_level, 0);
        check("cam_idle_after", mem_en, 0);
        check("cam_overflow", cam_overflow, 0);
        check_writes("cam_wr", 0, 'hA000, 4);

        // Display priority with interleaved camera writes.
        for (int i = 0; i < 12; i++) begin
            disp_re = 1; disp_addr = 17'(100 + i);
            cam_we = (i % 2 == 0); cam_addr = 17'(200 + i / 2);
            cam_wdata = 16'hB000 + 16'(i / 2);
            #1;
            check("disp_mem_addr", mem_addr, 100 + i);
            check("disp_mem_we", mem_we, 0);
            cyc();
            check("disp_rvalid", disp_rvalid, 1);
            check("disp_rdata", disp_rdata, pat(100 + i));
        end
        disp_re = 0; cam_we = 0;
        #1;
        check("disp_level6", fifo_level, 6);
        check("disp_drain_addr", mem_addr, 200);
        cyc();
        check("disp_rvalid_off", disp_rvalid, 0);
        repeat (5) cyc();
        check("disp_drained", fifo_level, 0);
        check("disp_no_ovf", cam_overflow, 0);
        check_writes("disp_wr", 200, 'hB000, 6);

        // Overflow: display holds the port while the camera writes every cycle.
        for (int i = 0; i < 20; i++) begin
            disp_re = 1; disp_addr = 17'(600 + i);
            cam_we = 1; cam_addr = 17'(300 + i); cam_wdata = 16'hC000 + 16'(i);
            cyc();
        end
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", cam_overflow, 1);
        disp_re = 0; cam_we = 0;
        repeat (8) cyc();
        check("ovf_drained", fifo_level, 0);
        check("ovf_sticky", cam_overflow, 1);
        clr_overflow = 1;
        cyc();
        clr_overflow = 0;
        check("ovf_cleared", cam_overflow, 0);
        check_writes("ovf_wr", 300, 'hC000, 8);

        // Processing handshake on an idle port.
        proc_req = 1; proc_addr = 17'h1234;
        #1;
        check("proc_ack", proc_ack, 1);
        check("proc_mem_addr", mem_addr, 'h1234);
        check("proc_mem_we", mem_we, 0);
        cyc();
        proc_req = 0;
        check("proc_rvalid", proc_rvalid, 1);
        check("proc_rdata", proc_rdata, pat('h1234));
        check("proc_disp_quiet", disp_rvalid, 0);
        check("proc_disp_rdata0", disp_rdata, 0);
        #1;
        check("proc_ack_drop", proc_ack, 0);

        // High-water camera drain outranks a pending processing read.
        for (int i = 0; i < 6; i++) begin
            disp_re = 1; disp_addr = 17'(700 + i);
            cam_we = 1; cam_addr = 17'(400 + i); cam_wdata = 16'hD000 + 16'(i);
            cyc();
        end
        disp_re = 0; cam_we = 0; proc_req = 1; proc_addr = 17'h2000;
        #1;
        check("hw_level6", fifo_level, 6);
        check("hw_no_ack", proc_ack, 0);
        check("hw_cam_addr", mem_addr, 400);
        cyc();
        #1;
        check("hw_level5", fifo_level, 5);
        check("hw_ack", proc_ack, 1);
        check("hw_proc_addr", mem_addr, 'h2000);
        cyc();
        proc_req = 0;
        check("hw_rvalid", proc_rvalid, 1);
        check("hw_rdata", proc_rdata, pat('h2000));
        repeat (5) cyc();
        check("hw_drained", fifo_level, 0);
        check_writes("hw_wr", 400, 'hD000, 6);

        // Reset with a burst queued and a display read in flight.
        for (int i = 0; i < 5; i++) begin
            disp_re = 1; disp_addr = 17'(800 + i);
            cam_we = 1; cam_addr = 17'(500 + i); cam_wdata = 16'hE000 + 16'(i);
            cyc();
        end
        cam_we = 0; disp_addr = 17'(805);
        check("rb_level5", fifo_level, 5);
        cyc();
        reset = 1; cam_we = 1; cam_addr = 17'(510); proc_req = 1; proc_addr = 17'h3000;
        #1;
        check("rb_mem_en", mem_en, 0);
        check("rb_mem_addr", mem_addr, 0);
        check("rb_proc_ack", proc_ack, 0);
        cyc();
        reset = 0; cam_we = 0; disp_re = 0; proc_req = 0;
        check("rb_level0", fifo_level, 0);
        check("rb_disp_rvalid", disp_rvalid, 0);
        check("rb_proc_rvalid", proc_rvalid, 0);
        check("rb_overflow", cam_overflow, 0);
        repeat (10) cyc();
        check("rb_no_writes", wr_addr_q.size(), 0);
        check("rb_level_end", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port 320×240×16 frame-buffer BRAM between three requesters:
- the camera pixel writer (OV7670 capture path, 1 write per 2 pclk);
- the VGA display reader;
- the dice-detection processing reader.

Camera writes are absorbed in a small FIFO so that none is lost while the display holds the port. The display gets fixed-latency reads. Processing reads are served in leftover cycles through a req/ack handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8: camera write FIFO entries; power of two, ≥4.
- HIGH_WATER, 6: FIFO level at which camera drain outranks processing reads.

Ports:
- clk  in  1  system clock. All interfaces are synchronous to clk.
- reset  in  1  synchronous, active-high.
- cam_we  in  1  camera write strobe, one cycle per pixel.
- cam_addr  in  17  pixel address, 0..76799.
- cam_wdata  in  16  RGB565 pixel.
- disp_re  in  1  display read strobe.
- disp_addr  in  17  display read address.
- disp_rdata  out  16  display read data.
- disp_rvalid  out  1  disp_rdata valid.
- proc_req  in  1  processing read request; held until acked.
- proc_addr  in  17  processing address; stable while proc_req is high.
- proc_ack  out  1  one-cycle pulse: request issued to memory.
- proc_rdata  out  16  processing read data.
- proc_rvalid  out  1  proc_rdata valid.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  17  BRAM address.
- mem_wdata  out  16  BRAM write data.
- mem_rdata  in  16  BRAM read data, registered in the BRAM, 1-cycle latency.
- clr_overflow  in  1  clears cam_overflow.
- cam_overflow  out  1  sticky: a camera write was dropped.
- fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- One memory access per cycle. The grant is computed combinationally from current inputs and registered FIFO state.
- Priority: display > camera drain (level ≥ HIGH_WATER) > processing > camera drain (level ≥ 1) > none.
- Memory port drive:
  - GNT_DISP: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - GNT_CAM: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; pop.
  - GNT_PROC: mem_en=1, mem_we=0, mem_addr=proc_addr; proc_ack=1.
  - GNT_NONE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FIFO push on cam_we:
  - Accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and cam_overflow is set.
  - Push and pop in the same cycle leave the level unchanged.
- Overflow flag:
  - clr_overflow clears cam_overflow.
  - If a drop and clr_overflow happen in the same cycle, the set wins.
- Read return routing: a registered 2-bit last_grant selects the return path in the next cycle.
  - disp_rvalid = (last_grant==GNT_DISP).
  - proc_rvalid = (last_grant==GNT_PROC).
  - disp_rdata and proc_rdata both equal mem_rdata when their valid is high, and 0 otherwise.
- Continuous display reads with a non-empty FIFO: the FIFO fills. The display pattern (640-pixel lines with blanking) keeps this bounded. An overflow here is a system error and is flagged, not prevented.
- Processing starvation is permitted while the display or a high FIFO is active.

## Timing
- Reset values:
  - disp_rvalid=0, proc_rvalid=0, proc_ack=0, mem_en=0, mem_we=0.
  - All data and address outputs 0.
  - cam_overflow=0, fifo_level=0, last_grant=GNT_NONE.
  - FIFO pointers 0.
- While reset is high, all mem outputs are 0 and all requests are ignored.
- Reset mid-operation:
  - FIFO contents are discarded.
  - An in-flight read returns no valid in the cycle after reset.
- Display: disp_re at cycle N → mem access at N → disp_rvalid/disp_rdata at N+1. Latency is fixed at 1 and is never stalled.
- Processing:
  - proc_ack in the grant cycle M; proc_rvalid at M+1.
  - The requester may drop proc_req, or present a new address, at M+1.
  - Back-to-back requests: at most one grant per cycle.
- Camera: a pushed write reaches memory no earlier than 1 cycle after the push (FIFO registered, no bypass).
- fifo_level is registered and reflects pushes and pops of the previous cycle.

## Structure
- Package fb_pkg:
  - FB_ADDR_W=17, FB_DATA_W=16, FB_WORDS=76800.
  - Enum grant_t {GNT_NONE, GNT_DISP, GNT_CAM, GNT_PROC}.
- Sub-module fb_wr_fifo:
  - Synchronous FIFO of {addr, data}, width 33, depth FIFO_DEPTH.
  - Ports: push, pop, head, level, full, empty.
  - Pop on empty and push on full (without pop) are no-ops.
- Top level: grant logic, memory mux, last_grant register, overflow flag.

## Test plan
- Camera only: 4 writes (addr 0..3, data 0xA000..0xA003) → 4 memory writes in order, each 1 cycle after its push; fifo_level returns to 0; cam_overflow=0.
- Display priority: disp_re every cycle for 12 cycles, cam_we every other cycle (6 writes) → all 12 display reads get disp_rvalid exactly 1 cycle later; FIFO reaches 6; writes drain after disp_re drops; no overflow.
- Overflow: disp_re held for 20 cycles, cam_we every cycle → level saturates at 8; writes 9+ are dropped; cam_overflow=1 until clr_overflow; the first 8 writes land in memory in order.
- Processing handshake: proc_req with addr 0x1234, port idle → proc_ack in the same cycle; proc_rvalid next cycle with data equal to the BRAM model contents.
- Water-mark priority: FIFO at 6 with proc_req pending → camera drain is granted first until level is 5, then proc_ack.
- Reset mid-burst: FIFO holding 5 entries with a read in flight, assert reset 1 cycle → level=0, no valid outputs, no subsequent stale writes to memory.
